// File: rtl/rom_rd_pkg.sv
// Shared definitions for the ROM burst reader: FSM state encoding and
// default datapath widths.
package rom_rd_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_LEN_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAP,
    HOLD,
    DONE
  } rd_state_t;

endpackage

// File: rtl/rom_reader.sv
// Burst initiator for a synchronous 1-cycle-latency ROM read port. Walks
// len consecutive addresses from base_addr (wrapping modulo 2**ADDR_W),
// captures each returned word and offers it on a valid/ready stream.
// Optional feature macro: ROM_RD_CHECKSUM_EN adds csum/csum_valid, a
// modulo-2**DATA_W sum of every handshaken word, reported with done.
module rom_reader
  import rom_rd_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              rom_read,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef ROM_RD_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] csum,
  output logic              csum_valid
`endif
);

  rd_state_t            state;
  logic [LEN_W-1:0]     remaining;

  // Burst sequencer: rom_addr doubles as the running address counter, and
  // rom_read is raised on the edge that enters REQ so it lasts exactly REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_read  <= 1'b0;
      rom_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      rom_read <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              rom_addr  <= base_addr;
              remaining <= len;
              rom_read  <= 1'b1;
              state     <= REQ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        REQ: begin
          state <= CAP;
        end
        CAP: begin
          out_data  <= rom_data;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rom_addr <= rom_addr + ADDR_W'(1);
              rom_read <= 1'b1;
              state    <= REQ;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ROM_RD_CHECKSUM_EN
  // Running sum of accepted words; cleared on an accepted start and
  // flagged on the same edges that raise done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum       <= '0;
      csum_valid <= 1'b0;
    end else begin
      csum_valid <= 1'b0;
      if (state == IDLE && start) begin
        csum <= '0;
        if (len == '0) begin
          csum_valid <= 1'b1;
        end
      end else if (state == HOLD && out_ready) begin
        csum <= csum + out_data;
        if (remaining == LEN_W'(1)) begin
          csum_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
